// File: rtl/planificador_acciones.sv
// Action scheduler: arbitrates feed/play/sleep requests, runs the animation handshake,
// enforces cooldown, generates the decay tick and the mood code. Optional statistics: PLANIFICADOR_ESTADISTICAS_EN.
module planificador_acciones #(
  parameter int unsigned CLK_FREQ        = 50000000,
  parameter int unsigned TICK_SEGUNDOS   = 25,
  parameter int unsigned COOLDOWN_CICLOS = 25000000,
  parameter int unsigned ANIM_MAX_CICLOS = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_alimentar,
  input  logic       req_jugar,
  input  logic       req_dormir,
  input  logic       test_mode,
  input  logic [2:0] nivel_hambre,
  input  logic [2:0] nivel_diversion,
  input  logic       anim_done,
  output logic       cmd_alimentar,
  output logic       cmd_jugar,
  output logic       cmd_decaer,
  output logic       anim_start,
  output logic [1:0] anim_id,
  output logic       ocupado,
`ifdef PLANIFICADOR_ESTADISTICAS_EN
  output logic [7:0] num_acciones,
  output logic [7:0] num_descartes,
`endif
  output logic [1:0] estado_animo
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_ANIM, S_COOLDOWN} estado_t;

  localparam logic [1:0] ANIM_COMER  = 2'd0;
  localparam logic [1:0] ANIM_JUGAR  = 2'd1;
  localparam logic [1:0] ANIM_DORMIR = 2'd2;
  localparam logic [1:0] ANIM_NEGAR  = 2'd3;

  localparam logic [1:0] ANIMO_FELIZ   = 2'd0;
  localparam logic [1:0] ANIMO_NEUTRAL = 2'd1;
  localparam logic [1:0] ANIMO_TRISTE  = 2'd2;

  localparam logic [63:0] PERIODO_NORMAL = 64'(CLK_FREQ) * 64'(TICK_SEGUNDOS);
  localparam logic [63:0] PERIODO_TEST   = 64'(CLK_FREQ);
  localparam logic [31:0] ANIM_LIM = (ANIM_MAX_CICLOS > 0) ? 32'(ANIM_MAX_CICLOS - 1) : 32'd0;
  localparam logic [31:0] CD_LIM   = (COOLDOWN_CICLOS > 0) ? 32'(COOLDOWN_CICLOS - 1) : 32'd0;

  // Out-of-range levels behave like the nearest legal bound.
  function automatic logic [2:0] acotar(input logic [2:0] n);
    if (n < 3'd1)      return 3'd1;
    else if (n > 3'd5) return 3'd5;
    else               return n;
  endfunction

  logic [2:0] hambre_c, diversion_c;
  assign hambre_c    = acotar(nivel_hambre);
  assign diversion_c = acotar(nivel_diversion);

  estado_t     estado, estado_sig;
  logic [31:0] cnt_fsm, cnt_fsm_sig;
  logic        cmd_alimentar_sig, cmd_jugar_sig, anim_start_sig;
  logic [1:0]  anim_id_sig;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    estado_sig        = estado;
    cnt_fsm_sig       = '0;
    cmd_alimentar_sig = 1'b0;
    cmd_jugar_sig     = 1'b0;
    anim_start_sig    = 1'b0;
    anim_id_sig       = anim_id;
    unique case (estado)
      S_IDLE: begin
        if (req_alimentar) begin
          estado_sig     = S_EMIT;
          anim_start_sig = 1'b1;
          if (hambre_c > 3'd1) begin
            cmd_alimentar_sig = 1'b1;
            anim_id_sig       = ANIM_COMER;
          end else begin
            anim_id_sig = ANIM_NEGAR;
          end
        end else if (req_jugar) begin
          estado_sig     = S_EMIT;
          anim_start_sig = 1'b1;
          if (diversion_c < 3'd5) begin
            cmd_jugar_sig = 1'b1;
            anim_id_sig   = ANIM_JUGAR;
          end else begin
            anim_id_sig = ANIM_NEGAR;
          end
        end else if (req_dormir) begin
          estado_sig     = S_EMIT;
          anim_start_sig = 1'b1;
          anim_id_sig    = ANIM_DORMIR;
        end
      end
      S_EMIT: estado_sig = S_ANIM;
      S_ANIM: begin
        if (anim_done || cnt_fsm >= ANIM_LIM) estado_sig = S_COOLDOWN;
        else                                  cnt_fsm_sig = cnt_fsm + 32'd1;
      end
      S_COOLDOWN: begin
        if (cnt_fsm >= CD_LIM) estado_sig = S_IDLE;
        else                   cnt_fsm_sig = cnt_fsm + 32'd1;
      end
      default: estado_sig = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode, so they line up with the state they describe.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado        <= S_IDLE;
      cnt_fsm       <= '0;
      cmd_alimentar <= 1'b0;
      cmd_jugar     <= 1'b0;
      anim_start    <= 1'b0;
      anim_id       <= ANIM_COMER;
      ocupado       <= 1'b0;
    end else begin
      estado        <= estado_sig;
      cnt_fsm       <= cnt_fsm_sig;
      cmd_alimentar <= cmd_alimentar_sig;
      cmd_jugar     <= cmd_jugar_sig;
      anim_start    <= anim_start_sig;
      anim_id       <= anim_id_sig;
      ocupado       <= (estado_sig != S_IDLE);
    end
  end

  logic [31:0] cnt_decay;
  logic        test_mode_q;
  logic [63:0] periodo;
  logic        pausa;

  assign periodo = test_mode ? PERIODO_TEST : PERIODO_NORMAL;
  assign pausa   = (estado == S_ANIM) && (anim_id == ANIM_DORMIR);

  // Sleeping freezes the decay counter; a test_mode edge restarts it silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_decay   <= '0;
      test_mode_q <= 1'b0;
      cmd_decaer  <= 1'b0;
    end else begin
      test_mode_q <= test_mode;
      cmd_decaer  <= 1'b0;
      if (test_mode != test_mode_q) begin
        cnt_decay <= '0;
      end else if (!pausa) begin
        if ({32'd0, cnt_decay} >= periodo - 64'd1) begin
          cnt_decay  <= '0;
          cmd_decaer <= 1'b1;
        end else begin
          cnt_decay <= cnt_decay + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                                       estado_animo <= ANIMO_NEUTRAL;
    else if (hambre_c == 3'd5 || diversion_c == 3'd1) estado_animo <= ANIMO_TRISTE;
    else if (hambre_c <= 3'd2 && diversion_c >= 3'd4) estado_animo <= ANIMO_FELIZ;
    else                                             estado_animo <= ANIMO_NEUTRAL;
  end

`ifdef PLANIFICADOR_ESTADISTICAS_EN
  logic [1:0] n_req, descartes_ciclo;
  logic [8:0] suma_descartes;

  // In IDLE only the winner survives; in any other state every request is lost.
  always_comb begin
    n_req = 2'(req_alimentar) + 2'(req_jugar) + 2'(req_dormir);
    descartes_ciclo = n_req;
    if (estado == S_IDLE) descartes_ciclo = (n_req == 2'd0) ? 2'd0 : n_req - 2'd1;
    suma_descartes = {1'b0, num_descartes} + {7'd0, descartes_ciclo};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_acciones  <= '0;
      num_descartes <= '0;
    end else begin
      if ((cmd_alimentar_sig || cmd_jugar_sig) && num_acciones != 8'hFF)
        num_acciones <= num_acciones + 8'd1;
      num_descartes <= suma_descartes[8] ? 8'hFF : suma_descartes[7:0];
    end
  end
`endif

endmodule

// File: doc/planificador_acciones.md
Name: planificador_acciones

Overview:
- Sequencing controller between the debounced buttons and the hunger/fun level datapath.
- Arbitrates feed/play/sleep requests and issues one-cycle commands to the level registers.
- Runs a start/done handshake with the display animation engine, enforces a cooldown, and generates the periodic decay tick, including an accelerated test mode.
- Derives a registered mood code for the display.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz.
- TICK_SEGUNDOS, 25, decay period in seconds in normal mode.
- COOLDOWN_CICLOS, 25000000, idle cycles enforced after each action.
- ANIM_MAX_CICLOS, 100000000, animation handshake timeout in cycles.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- req_alimentar  input  1  one-cycle feed request pulse, active high.
- req_jugar  input  1  one-cycle play request pulse.
- req_dormir  input  1  one-cycle sleep request pulse.
- test_mode  input  1  level-sensitive accelerated decay select.
- nivel_hambre  input  3  current hunger level, 1..5.
- nivel_diversion  input  3  current fun level, 1..5.
- anim_done  input  1  animation engine finished, one-cycle pulse.
- cmd_alimentar  output  1  one-cycle pulse: decrement hunger.
- cmd_jugar  output  1  one-cycle pulse: increment fun.
- cmd_decaer  output  1  one-cycle pulse: periodic decay.
- anim_start  output  1  one-cycle pulse: start animation.
- anim_id  output  2  animation code: 0 comer, 1 jugar, 2 dormir, 3 negar.
- ocupado  output  1  high whenever the FSM is not in IDLE.
- estado_animo  output  2  mood code: 0 feliz, 1 neutral, 2 triste.

Behaviour:
- Reset values: all outputs 0, except estado_animo = 1. FSM goes to IDLE, all counters go to 0. Reset has priority over all other inputs and aborts any state immediately.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: requests are sampled here. Priority is alimentar > jugar > dormir. Lower-priority simultaneous requests are dropped. A request arriving in any other state is dropped, with no queueing.
  - EMIT (one cycle, entered the cycle after the request is sampled in IDLE):
    - anim_start = 1 and anim_id is loaded.
    - alimentar with nivel_hambre > 1: cmd_alimentar = 1, anim_id = 0.
    - alimentar with nivel_hambre == 1: no command, anim_id = 3.
    - jugar with nivel_diversion < 5: cmd_jugar = 1, anim_id = 1.
    - jugar with nivel_diversion == 5: no command, anim_id = 3.
    - dormir: no command, anim_id = 2.
    - Next state is ANIM.
  - ANIM: waits for anim_done, then goes to COOLDOWN. If ANIM_MAX_CICLOS cycles elapse without anim_done, it goes to COOLDOWN anyway. An anim_done seen outside ANIM is ignored.
  - COOLDOWN: waits exactly COOLDOWN_CICLOS cycles, then goes to IDLE. With COOLDOWN_CICLOS = 0 it goes to IDLE on the next cycle.
- anim_id holds its value until the next EMIT.
- Decay tick:
  - Period P = CLK_FREQ*TICK_SEGUNDOS cycles, or CLK_FREQ cycles while test_mode = 1. Counter is at least 32 bits and compared as a 64-bit product.
  - Counter runs 0..P-1; cmd_decaer = 1 in the cycle after the counter reaches P-1, then the counter wraps to 0.
  - Any change of test_mode clears the counter to 0 with no pulse.
  - The counter is frozen while the state is ANIM with anim_id = 2 (sleep pauses decay).
  - Otherwise cmd_decaer is independent of the FSM. It may coincide with cmd_alimentar or cmd_jugar; both are asserted, and the datapath resolves the conflict.
- Mood (registered, 1-cycle latency from the level inputs):
  - triste if nivel_hambre == 5 or nivel_diversion == 1;
  - else feliz if nivel_hambre <= 2 and nivel_diversion >= 4;
  - else neutral.
- Out-of-range levels (0, 6, 7) are treated as their nearest bound (1 or 5) for both the accept/reject decision and the mood decision.

Optional Feature:
- Macro: PLANIFICADOR_ESTADISTICAS_EN.
- When defined:
  - Adds output num_acciones [7:0]: counts accepted commands (cmd_alimentar or cmd_jugar pulses), saturating at 255.
  - Adds output num_descartes [7:0]: counts requests dropped because the FSM was busy, or dropped as lower-priority simultaneous requests. Saturates at 255.
  - Both counters reset to 0.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Bench parameters: CLK_FREQ=10, TICK_SEGUNDOS=5, COOLDOWN_CICLOS=4, ANIM_MAX_CICLOS=20.
- Scenario 1: hambre=3, req_alimentar pulse at cycle N -> cmd_alimentar=1, anim_start=1, anim_id=0 at N+1; ocupado high; anim_done at N+5 -> IDLE at N+10, ocupado low.
- Scenario 2: diversion=5, req_jugar -> no cmd_jugar, anim_id=3 with anim_start; hambre=1, req_alimentar -> anim_id=3, no cmd_alimentar.
- Scenario 3: req_alimentar and req_jugar in the same cycle -> only cmd_alimentar; a req_jugar during ANIM is dropped; with the macro defined, num_descartes=2.
- Scenario 4: no requests -> cmd_decaer pulses every 50 cycles; raise test_mode -> next pulse 10 cycles after the change, then every 10 cycles; req_dormir with anim_done withheld -> decay paused for 20 cycles, then timeout to COOLDOWN.
- Scenario 5: hambre=5 -> estado_animo=2 one cycle later; hambre=2, diversion=4 -> 0; hambre=3, diversion=3 -> 1; reset asserted during ANIM -> IDLE next cycle, all outputs 0, estado_animo=1.
